ins_line_fill: RTL and testbench

INS_LINE_FILL -- requirements
Module: ins_line_fill

---
 rtl/spu_fetch_pkg.sv | 22 ++
 rtl/ins_line_fill_if.sv | 27 ++
 rtl/ins_fill_fsm.sv | 120 ++++++++++++
 rtl/ins_line_fill.sv | 109 ++++++++++
 tb/tb_ins_line_fill.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spu_fetch_pkg.sv
// Shared fetch-side definitions for the local-store line fill path:
// fill FSM state enum, buffer geometry and SPU no-op encodings.
package spu_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_FILL  = 2'd2,
        ST_FLUSH = 2'd3
    } fill_state_t;

    localparam int LINE_WORDS = 16;
    localparam int BEAT_WORDS = 4;

    localparam logic [31:0] SPU_NOP  = 32'h4020_0000;
    localparam logic [31:0] SPU_LNOP = 32'h0020_0000;

    function automatic logic [3:0] line_of(input logic [7:0] word_idx);
        return word_idx[7:4];
    endfunction

endpackage

// File: rtl/ins_line_fill_if.sv
// Local-store request/response bus between the line fill block (master)
// and the local store (slave).
interface ins_line_fill_if #(
    parameter int LS_LINE_W = 12
) ();
    logic                 ls_req;
    logic [LS_LINE_W-1:0] ls_line_addr;
    logic                 ls_gnt;
    logic                 ls_valid;
    logic [127:0]         ls_data;

    modport master (
        output ls_req,
        output ls_line_addr,
        input  ls_gnt,
        input  ls_valid,
        input  ls_data
    );

    modport slave (
        input  ls_req,
        input  ls_line_addr,
        output ls_gnt,
        output ls_valid,
        output ls_data
    );
endinterface

// File: rtl/ins_fill_fsm.sv
// Line fill sequencer: picks the line to fetch, holds the request until
// granted, then counts four data beats.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_IDLE  | no transaction; evaluate demand (and optional prefetch) miss
//   ST_REQ   | ls_req high for {page, fill_line}; waiting for ls_gnt
//   ST_FILL  | granted burst in flight; each ls_valid beat is written
//   ST_FLUSH | burst invalidated by new page; beats drained, not written
module ins_fill_fsm
    import spu_fetch_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       read_enable,
    input  logic       redirect,
    input  logic       ls_gnt,
    input  logic       ls_valid,
    input  logic       i_miss_pc,
    input  logic       i_miss_pc1,
    input  logic       i_miss_next,
    input  logic [3:0] i_pc_line,
    input  logic [3:0] i_pc1_line,
    input  logic [3:0] i_next_line,
    output logic [1:0] o_beat,
    output logic [3:0] o_fill_line,
    output logic       o_ls_req,
    output logic       o_wr_en,
    output logic       o_set_valid,
    output logic       o_busy,
    output logic       o_flush
);

    fill_state_t r_state;
    fill_state_t w_state_nxt;
    logic [1:0]  r_beat;
    logic [1:0]  w_beat_nxt;
    logic [3:0]  r_fill_line;
    logic [3:0]  w_fill_line_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_beat      <= 2'd0;
            r_fill_line <= 4'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_beat      <= w_beat_nxt;
            r_fill_line <= w_fill_line_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_beat_nxt      = r_beat;
        w_fill_line_nxt = r_fill_line;
        case (r_state)
            ST_IDLE: begin
                // A page change this cycle invalidates everything, so defer
                // the miss decision until the cleared vector is visible.
                if (!read_enable) begin
                    if (i_miss_pc) begin
                        w_state_nxt     = ST_REQ;
                        w_fill_line_nxt = i_pc_line;
                    end else if (i_miss_pc1) begin
                        w_state_nxt     = ST_REQ;
                        w_fill_line_nxt = i_pc1_line;
                    end else if (i_miss_next) begin
                        w_state_nxt     = ST_REQ;
                        w_fill_line_nxt = i_next_line;
                    end
                end
            end
            ST_REQ: begin
                if (read_enable) begin
                    w_state_nxt = ST_IDLE;
                end else if (ls_gnt) begin
                    w_state_nxt = ST_FILL;
                    w_beat_nxt  = 2'd0;
                end else if (redirect) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FILL: begin
                if (ls_valid) begin
                    w_beat_nxt = r_beat + 2'd1;
                    if (r_beat == 2'd3) begin
                        w_state_nxt = ST_IDLE;
                    end else if (read_enable) begin
                        w_state_nxt = ST_FLUSH;
                    end
                end else if (read_enable) begin
                    w_state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (ls_valid) begin
                    w_beat_nxt = r_beat + 2'd1;
                    if (r_beat == 2'd3) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        o_ls_req    = (r_state == ST_REQ);
        o_busy      = (r_state != ST_IDLE);
        o_flush     = (r_state == ST_FLUSH);
        o_wr_en     = (r_state == ST_FILL) && ls_valid && !read_enable;
        o_set_valid = o_wr_en && (r_beat == 2'd3);
        o_beat      = r_beat;
        o_fill_line = r_fill_line;
    end

endmodule

// File: rtl/ins_line_fill.sv
// Instruction line buffer filled from local store in 64B lines; tracks
// per-line validity for the current page. Define NEXT_LINE_PREFETCH_EN to
// prefetch the line after pc when both demand lines are already valid.
module ins_line_fill
    import spu_fetch_pkg::*;
#(
    parameter int LS_LINE_W = 12,
    parameter int NUM_LINES = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 read_enable,
    input  logic [7:0]           ls_page,
    input  logic [7:0]           pc,
    input  logic                 redirect,
    ins_line_fill_if.master      ls,
    output logic [255:0][31:0]   ins_cache,
    output logic                 fetch_ready,
    output logic                 busy
);

    logic [7:0]            r_page;
    logic [NUM_LINES-1:0]  r_line_valid;
    logic [255:0][31:0]    r_ins_cache;

    logic [7:0] w_pc1;
    logic [3:0] w_pc_line;
    logic [3:0] w_pc1_line;
    logic [3:0] w_next_line;
    logic       w_miss_pc;
    logic       w_miss_pc1;
    logic       w_miss_next;
    logic [1:0] w_beat;
    logic [3:0] w_fill_line;
    logic       w_ls_req;
    logic       w_wr_en;
    logic       w_set_valid;
    logic       w_busy;
    logic       w_flush;
    logic [7:0] w_wr_base;

    assign w_pc1       = pc + 8'd1;
    assign w_pc_line   = line_of(pc);
    assign w_pc1_line  = line_of(w_pc1);
    assign w_next_line = w_pc_line + 4'd1;
    assign w_miss_pc   = !r_line_valid[w_pc_line];
    assign w_miss_pc1  = !r_line_valid[w_pc1_line];

`ifdef NEXT_LINE_PREFETCH_EN
    assign w_miss_next = !r_line_valid[w_next_line];
`else
    assign w_miss_next = 1'b0;
`endif

    ins_fill_fsm u_fsm (
        .clk         (clk),
        .reset       (reset),
        .read_enable (read_enable),
        .redirect    (redirect),
        .ls_gnt      (ls.ls_gnt),
        .ls_valid    (ls.ls_valid),
        .i_miss_pc   (w_miss_pc),
        .i_miss_pc1  (w_miss_pc1),
        .i_miss_next (w_miss_next),
        .i_pc_line   (w_pc_line),
        .i_pc1_line  (w_pc1_line),
        .i_next_line (w_next_line),
        .o_beat      (w_beat),
        .o_fill_line (w_fill_line),
        .o_ls_req    (w_ls_req),
        .o_wr_en     (w_wr_en),
        .o_set_valid (w_set_valid),
        .o_busy      (w_busy),
        .o_flush     (w_flush)
    );

    // Page change wins over a same-cycle line completion: the new page
    // must start with an empty valid vector.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_page       <= 8'd0;
            r_line_valid <= '0;
        end else if (read_enable) begin
            r_page       <= ls_page;
            r_line_valid <= '0;
        end else if (w_set_valid) begin
            r_line_valid[w_fill_line] <= 1'b1;
        end
    end

    assign w_wr_base = 8'(int'(w_fill_line) * LINE_WORDS + int'(w_beat) * BEAT_WORDS);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ins_cache <= '0;
        end else if (w_wr_en) begin
            for (int b = 0; b < BEAT_WORDS; b++) begin
                r_ins_cache[w_wr_base + 8'(b)] <= ls.ls_data[32*b +: 32];
            end
        end
    end

    assign ls.ls_req       = w_ls_req;
    assign ls.ls_line_addr = LS_LINE_W'({r_page, w_fill_line});
    assign ins_cache       = r_ins_cache;
    assign fetch_ready     = r_line_valid[w_pc_line] && r_line_valid[w_pc1_line] && !w_flush;
    assign busy            = w_busy;

endmodule

// File: tb/tb_ins_line_fill.sv
// Randomized bench for ins_line_fill against a transaction-level model of
// line validity, pending request and remaining burst beats.
module tb_ins_line_fill;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                read_enable = 1'b0;
    logic [7:0]          ls_page = 8'd0;
    logic [7:0]          pc = 8'd0;
    logic                redirect = 1'b0;
    logic [255:0][31:0]  ins_cache;
    logic                fetch_ready;
    logic                busy;

    ins_line_fill_if #(.LS_LINE_W(12)) ls_bus ();

    ins_line_fill dut (
        .clk         (clk),
        .reset       (reset),
        .read_enable (read_enable),
        .ls_page     (ls_page),
        .pc          (pc),
        .redirect    (redirect),
        .ls          (ls_bus),
        .ins_cache   (ins_cache),
        .fetch_ready (fetch_ready),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // model: which lines hold good data, what is requested, beats still owed
    bit          m_valid [16];
    logic [31:0] m_cache [256];
    logic [7:0]  m_page;
    logic [3:0]  m_line;
    bit          m_req;
    int          m_left;
    bit          m_keep;
    bit          m_in_reset;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        for (int i = 0; i < 256; i++) m_cache[i] = 32'd0;
        m_page = 8'd0;
        m_line = 4'd0;
        m_req  = 1'b0;
        m_left = 0;
        m_keep = 1'b0;
    endtask

    task automatic compare_all();
        logic [7:0] p1;
        logic [3:0] pl, p1l;
        bit         draining, exp_fr;
        int         k;
        p1       = pc + 8'd1;
        pl       = pc[7:4];
        p1l      = p1[7:4];
        draining = (m_left > 0) && !m_keep;
        exp_fr   = m_valid[pl] && m_valid[p1l] && !draining;
        chk("ls_req", 32'(ls_bus.ls_req), 32'(m_req));
        chk("busy", 32'(busy), 32'(m_req || m_left > 0));
        chk("fetch_ready", 32'(fetch_ready), 32'(exp_fr));
        if (m_in_reset)
            chk("ls_line_addr_rst", 32'(ls_bus.ls_line_addr), 32'd0);
        else if (m_req)
            chk("ls_line_addr", 32'(ls_bus.ls_line_addr), 32'({m_page, m_line}));
        k = 0;
        for (int i = 255; i >= 0; i--) if (ins_cache[i] !== m_cache[i]) k = i;
        chk($sformatf("ins_cache[%0d]", k), ins_cache[k], m_cache[k]);
    endtask

    task automatic m_step();
        logic [7:0] p1;
        logic [3:0] pl, p1l, nl;
        int         beat_no;
        p1  = pc + 8'd1;
        pl  = pc[7:4];
        p1l = p1[7:4];
        nl  = pl + 4'd1;
        if (m_left > 0) begin
            if (ls_bus.ls_valid) begin
                beat_no = 4 - m_left;
                if (m_keep && !read_enable) begin
                    for (int b = 0; b < 4; b++)
                        m_cache[int'(m_line) * 16 + beat_no * 4 + b] = ls_bus.ls_data[32*b +: 32];
                    if (m_left == 1) m_valid[m_line] = 1'b1;
                end
                m_left--;
            end
            if (read_enable) m_keep = 1'b0;
        end else if (m_req) begin
            if (read_enable) begin
                m_req = 1'b0;
            end else if (ls_bus.ls_gnt) begin
                m_req  = 1'b0;
                m_left = 4;
                m_keep = 1'b1;
            end else if (redirect) begin
                m_req = 1'b0;
            end
        end else if (!read_enable) begin
            if (!m_valid[pl]) begin
                m_req = 1'b1; m_line = pl;
            end else if (!m_valid[p1l]) begin
                m_req = 1'b1; m_line = p1l;
            end
`ifdef NEXT_LINE_PREFETCH_EN
            else if (!m_valid[nl]) begin
                m_req = 1'b1; m_line = nl;
            end
`endif
        end
        if (read_enable) begin
            for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
            m_page = ls_page;
        end
    endtask

    task automatic step(input bit re, input logic [7:0] pg, input logic [7:0] p,
                        input bit rd, input bit g, input bit v, input logic [127:0] d);
        read_enable     = re;
        ls_page         = pg;
        pc              = p;
        redirect        = rd;
        ls_bus.ls_gnt   = g;
        ls_bus.ls_valid = v;
        ls_bus.ls_data  = d;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        m_step();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_reset();
        m_in_reset = 1'b1;
        @(negedge clk);
        compare_all();
        @(posedge clk);
        #1;
        reset      = 1'b1;
        m_in_reset = 1'b0;
    endtask

    function automatic logic [127:0] beat_data(input logic [3:0] line, input int bt);
        logic [127:0] d;
        for (int b = 0; b < 4; b++)
            d[32*b +: 32] = 32'hC0DE_0000 | 32'(int'(line) * 16 + bt * 4 + b);
        return d;
    endfunction

    task automatic idle(input logic [7:0] p);
        step(1'b0, 8'd0, p, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic clear(input logic [7:0] pg, input logic [7:0] p);
        step(1'b1, pg, p, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic beats(input logic [7:0] p, input logic [3:0] line);
        for (int bt = 0; bt < 4; bt++)
            step(1'b0, 8'd0, p, 1'b0, 1'b0, 1'b1, beat_data(line, bt));
    endtask

    task automatic burst(input logic [7:0] p, input logic [3:0] line);
        step(1'b0, 8'd0, p, 1'b0, 1'b1, 1'b0, '0);
        beats(p, line);
    endtask

    initial begin
        ls_bus.ls_gnt   = 1'b0;
        ls_bus.ls_valid = 1'b0;
        ls_bus.ls_data  = '0;
        m_reset();
        do_reset();

        // cold start at pc=0: line 0 requested then filled
        idle(8'h00);
        chk("cold_req", 32'(ls_bus.ls_req), 32'd1);
        chk("cold_addr", 32'(ls_bus.ls_line_addr), 32'h000);
        burst(8'h00, 4'd0);
        chk("cold_word5", ins_cache[5], 32'hC0DE_0005);
        chk("cold_ready", 32'(fetch_ready), 32'd1);
        chk("cold_busy", 32'(busy), 32'd0);
`ifdef NEXT_LINE_PREFETCH_EN
        idle(8'h00);
        chk("pf_req", 32'(ls_bus.ls_req), 32'd1);
        chk("pf_addr", 32'(ls_bus.ls_line_addr), 32'h001);
`endif

        // pc=15 straddles lines 0 and 1
        clear(8'h00, 8'h0F);
        idle(8'h0F);
        chk("straddle_first", 32'(ls_bus.ls_line_addr), 32'h000);
        burst(8'h0F, 4'd0);
        chk("straddle_half", 32'(fetch_ready), 32'd0);
        idle(8'h0F);
        chk("straddle_second", 32'(ls_bus.ls_line_addr), 32'h001);
        burst(8'h0F, 4'd1);
        chk("straddle_ready", 32'(fetch_ready), 32'd1);

        // pc=255 wraps to line 0
        clear(8'h00, 8'hFF);
        idle(8'hFF);
        chk("wrap_first", 32'(ls_bus.ls_line_addr), 32'h00F);
        burst(8'hFF, 4'd15);
        idle(8'hFF);
        chk("wrap_second", 32'(ls_bus.ls_line_addr), 32'h000);
        burst(8'hFF, 4'd0);
        chk("wrap_ready", 32'(fetch_ready), 32'd1);

        // redirect aborts ungranted request; coincident grant wins
        clear(8'h00, 8'h40);
        idle(8'h40);
        step(1'b0, 8'd0, 8'h40, 1'b1, 1'b0, 1'b0, '0);
        chk("redir_drop", 32'(ls_bus.ls_req), 32'd0);
        idle(8'h40);
        chk("redir_rereq", 32'(ls_bus.ls_req), 32'd1);
        step(1'b0, 8'd0, 8'h40, 1'b1, 1'b1, 1'b0, '0);
        chk("redir_gnt_busy", 32'(busy), 32'd1);
        chk("redir_gnt_req", 32'(ls_bus.ls_req), 32'd0);
        beats(8'h40, 4'd4);
        chk("redir_ready", 32'(fetch_ready), 32'd1);

        // new page during beat 1 drains the burst without writes
        clear(8'h00, 8'h20);
        idle(8'h20);
        chk("flush_addr0", 32'(ls_bus.ls_line_addr), 32'h002);
        step(1'b0, 8'd0, 8'h20, 1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 8'd0, 8'h20, 1'b0, 1'b0, 1'b1, beat_data(4'd2, 0));
        step(1'b1, 8'h05, 8'h20, 1'b0, 1'b0, 1'b1, beat_data(4'd2, 1));
        chk("flush_ready", 32'(fetch_ready), 32'd0);
        chk("flush_busy", 32'(busy), 32'd1);
        step(1'b0, 8'd0, 8'h20, 1'b0, 1'b0, 1'b1, beat_data(4'd2, 2));
        step(1'b0, 8'd0, 8'h20, 1'b0, 1'b0, 1'b1, beat_data(4'd2, 3));
        chk("flush_idle", 32'(busy), 32'd0);
        chk("flush_beat0", ins_cache[32], 32'hC0DE_0020);
        chk("flush_beat1", ins_cache[36], 32'h0000_0000);
        idle(8'h20);
        chk("flush_newpage", 32'(ls_bus.ls_line_addr), 32'h052);

        // randomized traffic, including stray grants/beats and mid-burst resets
        begin
            logic [7:0] rp;
            rp = 8'h20;
            for (int c = 0; c < 3000; c++) begin
                if ($urandom_range(0, 11) == 0) rp = 8'($urandom_range(0, 255));
                if ($urandom_range(0, 499) == 0) begin
                    do_reset();
                end else begin
                    step($urandom_range(0, 59) == 0,
                         8'($urandom_range(0, 255)),
                         rp,
                         $urandom_range(0, 7) == 0,
                         $urandom_range(0, 2) == 0,
                         $urandom_range(0, 1) == 0,
                         {$urandom, $urandom, $urandom, $urandom});
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
